ps2_rx_core: RTL

PS/2 device-to-host receiver core. It samples the raw ps2_clk/ps2_dat lines driven by a keyboard or mouse (or the keyboard bench model) and synchronizes them into clk_i. It deframes the 11-bit PS/2 frame (start, 8 data LSB-first, odd parity, stop), checks it, and buffers good bytes in a small FIFO. The FIFO output is a valid/ready stream consumed by the PS/2 controller's register interface.

---
 rtl/ps2_rx_core.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_rx_core.sv
// PS/2 device-to-host receiver: line synchronizers, ps2_clk glitch filter,
// 11-bit frame deframer (parity/stop/timeout checks) and a FWFT byte FIFO.
module ps2_rx_core #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 2000
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic                          clr_i,
  input  logic                          ps2_clk_i,
  input  logic                          ps2_dat_i,
  output logic [7:0]                    dat_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   cnt_o,
  output logic                          par_err_o,
  output logic                          frm_err_o,
  output logic                          ovf_o,
  output logic                          busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic {IDLE, DATA} state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   s_clk, s_dat;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat_i};
    end
  end

  assign s_clk = clk_sync_q[SYNC_STAGES-1];
  assign s_dat = dat_sync_q[SYNC_STAGES-1];

  // Filtered clock flips only after FILT_LEN consecutive disagreeing samples.
  logic          filt_q, filt_d, filt_prev_q;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall;

  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (s_clk != filt_q) begin
      if (fcnt_q == FW'(FILT_LEN - 1)) filt_d = s_clk;
      else                             fcnt_d = fcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      fcnt_q      <= '0;
    end else begin
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      fcnt_q      <= fcnt_d;
    end
  end

  assign fall = filt_prev_q & ~filt_q;

  state_t        state_q;
  logic [3:0]    bitcnt_q;
  logic [8:0]    shift_q;
  logic [TW-1:0] tmo_q;
  logic          par_err_q, frm_err_q;
  logic          push_d;

  // shift_q holds {parity, data[7:0]} once nine bits are in; stop bit is live.
  assign push_d = en_i && (state_q == DATA) && fall && (bitcnt_q == 4'd9) &&
                  s_dat && (^shift_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      bitcnt_q  <= '0;
      shift_q   <= '0;
      tmo_q     <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      if (!en_i) begin
        state_q  <= IDLE;
        bitcnt_q <= '0;
        tmo_q    <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (fall && !s_dat) begin
              state_q  <= DATA;
              bitcnt_q <= '0;
              shift_q  <= '0;
              tmo_q    <= '0;
            end
          end
          DATA: begin
            if (fall) begin
              tmo_q <= '0;
              if (bitcnt_q == 4'd9) begin
                state_q <= IDLE;
                if (!s_dat)         frm_err_q <= 1'b1;
                else if (!(^shift_q)) par_err_q <= 1'b1;
              end else begin
                shift_q  <= {s_dat, shift_q[8:1]};
                bitcnt_q <= bitcnt_q + 1'b1;
              end
            end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
              frm_err_q <= 1'b1;
              state_q   <= IDLE;
              tmo_q     <= '0;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // FIFO: pointers carry an extra wrap bit so full and empty are distinct.
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt_w;
  logic        empty, full, pop, wr_en;
  logic        ovf_q, ovf_d;

  assign cnt_w = wr_ptr_q - rd_ptr_q;
  assign empty = (cnt_w == '0);
  assign full  = (cnt_w == (AW+1)'(FIFO_DEPTH));
  assign pop   = ~empty & ready_i;
  assign wr_en = push_d & (~full | pop) & ~clr_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = 1'b0;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      ovf_d = push_d & full & ~pop;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= shift_q[7:0];
  end

  assign dat_o     = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign valid_o   = ~empty;
  assign cnt_o     = cnt_w;
  assign par_err_o = par_err_q;
  assign frm_err_o = frm_err_q;
  assign ovf_o     = ovf_q;
  assign busy_o    = (state_q != IDLE);

endmodule
